// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the signed-by-unsigned sequential divider.
package seq_div_pkg;

  localparam int unsigned WD_DEF = 8;
  localparam int unsigned WS_DEF = 4;
  localparam int unsigned CW_DEF = $clog2(WD_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_su8_if.sv
// Operand/result valid-ready bus of the signed-by-unsigned divider.
interface seq_div_su8_if #(
  parameter int unsigned WD = 8,
  parameter int unsigned WS = 4
);

  logic          in_valid;
  logic          in_ready;
  logic [WD-1:0] s;
  logic [WS-1:0] u;
  logic          out_valid;
  logic          out_ready;
  logic [WD-1:0] q;
  logic [WS:0]   r;
  logic          dz;

  modport master (
    output in_valid, s, u, out_ready,
    input  in_ready, out_valid, q, r, dz
  );

  modport slave (
    input  in_valid, s, u, out_ready,
    output in_ready, out_valid, q, r, dz
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WS = 4
) (
  input  logic [WS:0]   pr,
  input  logic          bit_in,
  input  logic [WS-1:0] u,
  output logic [WS:0]   pr_next,
  output logic          q_bit
);

  localparam int unsigned TW = WS + 2;
  localparam int unsigned PW = WS + 1;

  logic [TW-1:0] t;
  logic [TW-1:0] ue;

  // Partial remainder stays below the divisor, so the top bit of t is always zero in use.
  always_comb begin
    t       = {pr, bit_in};
    ue      = TW'(u);
    q_bit   = (t >= ue);
    pr_next = q_bit ? PW'(t - ue) : PW'(t);
  end

endmodule

// File: rtl/seq_div_su8.sv
// Iterative signed-dividend / unsigned-divisor divider, one quotient bit per cycle.
module seq_div_su8
  import seq_div_pkg::*;
#(
  parameter int unsigned WD = WD_DEF,
  parameter int unsigned WS = WS_DEF
) (
  input logic           clk,
  input logic           rst,
  seq_div_su8_if.slave  bus
);

  localparam int unsigned CW = (WD > 1) ? $clog2(WD) : 1;

  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          last_step;
  logic [CW-1:0] count;
  logic [WD-1:0] mag;
  logic          neg;
  logic [WS-1:0] dvs;
  logic [WS:0]   pr;
  logic [WS:0]   pr_next;
  logic          q_bit;
  logic [WD-1:0] qmag;

  div_step #(.WS(WS)) u_step (
    .pr      (pr),
    .bit_in  (mag[WD-1]),
    .u       (dvs),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  assign qmag         = {mag[WD-2:0], q_bit};
  assign bus.in_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and control strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = (bus.u == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (count == CW'(WD - 1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      mag           <= '0;
      neg           <= 1'b0;
      dvs           <= '0;
      pr            <= '0;
      bus.q         <= '0;
      bus.r         <= '0;
      bus.dz        <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      // |s| fits WD unsigned bits, including the most negative dividend.
      mag   <= bus.s[WD-1] ? WD'(-bus.s) : bus.s;
      neg   <= bus.s[WD-1];
      dvs   <= bus.u;
      pr    <= '0;
      count <= '0;
      if (bus.u == '0) begin
        bus.q         <= bus.s[WD-1] ? {1'b1, {(WD-1){1'b0}}} : {1'b0, {(WD-1){1'b1}}};
        bus.r         <= '0;
        bus.dz        <= 1'b1;
        bus.out_valid <= 1'b1;
      end
    end else if (state == CALC) begin
      pr    <= pr_next;
      mag   <= qmag;
      count <= count + CW'(1);
      if (last_step) begin
        bus.q         <= neg ? WD'(-qmag) : qmag;
        bus.r         <= neg ? (WS+1)'(-pr_next) : pr_next;
        bus.dz        <= 1'b0;
        bus.out_valid <= 1'b1;
      end
    end else if (state == DONE && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_div_su8.sv
// Directed and exhaustive checks of seq_div_su8 against a truncating-division reference.
module tb_seq_div_su8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seq_div_su8_if #(.WD(8), .WS(4)) bus ();

  seq_div_su8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result packed as {dz, q[7:0], r[4:0]}.
  function automatic logic [13:0] model(input logic [7:0] s, input logic [3:0] u);
    int si, ui, qi, ri;
    si = int'($signed(s));
    ui = int'(u);
    if (ui == 0) begin
      qi = (si < 0) ? -128 : 127;
      return {1'b1, 8'(qi), 5'd0};
    end
    qi = si / ui;
    ri = si % ui;
    return {1'b0, 8'(qi), 5'(ri)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand pair and wait for the result; leaves it pending in DONE.
  task automatic issue(input logic [7:0] s, input logic [3:0] u, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.s        = s;
    bus.u        = u;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("ov_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_after", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] s, input logic [3:0] u,
                        input logic [7:0] eq, input logic [4:0] er, input logic edz);
    int lat;
    issue(s, u, lat);
    check({tag, "_lat"}, 32'(lat), (u == 4'd0) ? 32'd0 : 32'd8);
    check({tag, "_q"}, 32'(bus.q), 32'(eq));
    check({tag, "_r"}, 32'(bus.r), 32'(er));
    check({tag, "_dz"}, 32'(bus.dz), 32'(edz));
    release_result();
  endtask

  initial begin
    int lat;
    logic [13:0] m;
    logic [7:0] hq;
    logic [4:0] hr;
    logic hdz;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.s         = '0;
    bus.u         = '0;
    repeat (2) tick();
    check("rst_ov", 32'(bus.out_valid), 32'd0);
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_r", 32'(bus.r), 32'd0);
    check("rst_dz", 32'(bus.dz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors with hand-computed results.
    run_op("p100_7",  8'd100,  4'd7,  8'h0E, 5'b00010, 1'b0);
    run_op("n100_7",  8'h9C,   4'd7,  8'hF2, 5'b11110, 1'b0);
    run_op("n128_1",  8'h80,   4'd1,  8'h80, 5'b00000, 1'b0);
    run_op("n1_15",   8'hFF,   4'd15, 8'h00, 5'b11111, 1'b0);
    run_op("p5_0",    8'd5,    4'd0,  8'h7F, 5'b00000, 1'b1);
    run_op("n5_0",    8'hFB,   4'd0,  8'h80, 5'b00000, 1'b1);
    run_op("p127_15", 8'd127,  4'd15, 8'h08, 5'b00111, 1'b0);
    run_op("p0_3",    8'd0,    4'd3,  8'h00, 5'b00000, 1'b0);

    // Backpressure: results hold and busy-time in_valid is ignored.
    issue(8'd100, 4'd7, lat);
    check("bp_lat", 32'(lat), 32'd8);
    bus.s        = 8'd1;
    bus.u        = 4'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ov", 32'(bus.out_valid), 32'd1);
      check("bp_q", 32'(bus.q), 32'h0E);
      check("bp_r", 32'(bus.r), 32'h02);
      check("bp_dz", 32'(bus.dz), 32'd0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    release_result();
    check("bp_q_kept", 32'(bus.q), 32'h0E);

    // Reset in the middle of CALC drops the pending result.
    bus.s        = 8'd100;
    bus.u        = 4'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("abort_ov", 32'(bus.out_valid), 32'd0);
    check("abort_q", 32'(bus.q), 32'd0);
    check("abort_r", 32'(bus.r), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    repeat (10) begin
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
      tick();
    end
    run_op("p9_3", 8'd9, 4'd3, 8'h03, 5'b00000, 1'b0);

    // Every dividend/divisor pair against the reference.
    for (int si = 0; si < 256; si++) begin
      for (int ui = 0; ui < 16; ui++) begin
        m   = model(8'(si), 4'(ui));
        hdz = m[13];
        hq  = m[12:5];
        hr  = m[4:0];
        issue(8'(si), 4'(ui), lat);
        check("ex_lat", 32'(lat), (ui == 0) ? 32'd0 : 32'd8);
        check("ex_q", 32'(bus.q), 32'(hq));
        check("ex_r", 32'(bus.r), 32'(hr));
        check("ex_dz", 32'(bus.dz), 32'(hdz));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("ex_ov_drop", 32'(bus.out_valid), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
